// File: rtl/udma_hyper_ch_sched.sv
// Round-robin burst scheduler that shares one hyperbus PHY command path between NB_CH channels.
// Each request is split into bursts of at most BURST_BYTES and arbitration repeats after every burst.
module udma_hyper_ch_sched #(
    parameter int unsigned NB_CH       = 8,
    parameter int unsigned TRANS_SIZE  = 16,
    parameter int unsigned BURST_BYTES = 512
) (
    input  logic                                sys_clk_i,
    input  logic                                rst_i,
    input  logic [NB_CH-1:0]                    ch_req_i,
    output logic [NB_CH-1:0]                    ch_ack_o,
    input  logic [NB_CH-1:0][31:0]              ch_addr_i,
    input  logic [NB_CH-1:0][TRANS_SIZE-1:0]    ch_len_i,
    input  logic [NB_CH-1:0]                    ch_rw_i,
    input  logic [NB_CH-1:0]                    ch_clr_i,
    output logic                                trans_valid_o,
    input  logic                                trans_ready_i,
    output logic [31:0]                         trans_addr_o,
    output logic [TRANS_SIZE-1:0]               trans_len_o,
    output logic                                trans_rw_o,
    output logic [$clog2(NB_CH)-1:0]            trans_id_o,
    input  logic                                trans_done_i,
    output logic [NB_CH-1:0]                    evt_eot_o,
    output logic                                busy_o
);

    localparam int unsigned IdW = $clog2(NB_CH);
    localparam logic [TRANS_SIZE-1:0] BurstLen = TRANS_SIZE'(BURST_BYTES);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                           state_q, state_d;
    logic [NB_CH-1:0]                 active_q, active_d;
    logic [NB_CH-1:0]                 abort_q, abort_d;
    logic [NB_CH-1:0]                 rw_q, rw_d;
    logic [NB_CH-1:0]                 eot_q, eot_d;
    logic [NB_CH-1:0][31:0]           addr_q, addr_d;
    logic [NB_CH-1:0][TRANS_SIZE-1:0] left_q, left_d;
    logic [IdW-1:0]                   rr_q, rr_d, id_q, id_d, sel_id;
    logic [TRANS_SIZE-1:0]            chunk_q, chunk_d, left_rem;
    logic                             sel_found;
    logic                             busy_q;

    // A channel is captured only while its context is free; clear wins over request.
    always_comb begin
        ch_ack_o = ch_req_i & ~active_q & ~ch_clr_i & {NB_CH{~rst_i}};
    end

    // First active channel at or above the round-robin pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int unsigned i = 0; i < NB_CH; i++) begin
            idx = (32'(rr_q) + i) % NB_CH;
            if (!sel_found && active_q[idx] && !ch_clr_i[idx]) begin
                sel_found = 1'b1;
                sel_id    = IdW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        abort_d  = abort_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        left_d   = left_q;
        rr_d     = rr_q;
        id_d     = id_q;
        chunk_d  = chunk_q;
        eot_d    = '0;
        left_rem = left_q[id_q] - chunk_q;

        for (int c = 0; c < NB_CH; c++) begin
            if (ch_ack_o[c]) begin
                addr_d[c]   = ch_addr_i[c];
                left_d[c]   = ch_len_i[c];
                rw_d[c]     = ch_rw_i[c];
                active_d[c] = |ch_len_i[c];
                abort_d[c]  = 1'b0;
                eot_d[c]    = ~|ch_len_i[c];
            end else if (ch_clr_i[c]) begin
                // The in-flight burst cannot be retracted, so defer the clear to its done.
                if (state_q != StIdle && id_q == IdW'(c)) begin
                    abort_d[c] = 1'b1;
                end else begin
                    active_d[c] = 1'b0;
                    abort_d[c]  = 1'b0;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    id_d    = sel_id;
                    chunk_d = (left_q[sel_id] > BurstLen) ? BurstLen : left_q[sel_id];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (trans_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (trans_done_i) begin
                    addr_d[id_q] = addr_q[id_q] + 32'(chunk_q);
                    left_d[id_q] = left_rem;
                    rr_d         = (id_q == IdW'(NB_CH - 1)) ? '0 : id_q + IdW'(1);
                    state_d      = StIdle;
                    if (abort_q[id_q] || ch_clr_i[id_q]) begin
                        active_d[id_q] = 1'b0;
                        abort_d[id_q]  = 1'b0;
                    end else if (left_rem == '0) begin
                        active_d[id_q] = 1'b0;
                        eot_d[id_q]    = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            active_q <= '0;
            abort_q  <= '0;
            rw_q     <= '0;
            addr_q   <= '0;
            left_q   <= '0;
            rr_q     <= '0;
            id_q     <= '0;
            chunk_q  <= '0;
            eot_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            abort_q  <= abort_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            chunk_q  <= chunk_d;
            eot_q    <= eot_d;
            busy_q   <= (|active_d) || (state_d != StIdle);
        end
    end

    assign trans_valid_o = (state_q == StIssue);
    assign trans_addr_o  = addr_q[id_q];
    assign trans_len_o   = chunk_q;
    assign trans_rw_o    = rw_q[id_q];
    assign trans_id_o    = id_q;
    assign evt_eot_o     = eot_q;
    assign busy_o        = busy_q;

endmodule

// File: doc/udma_hyper_ch_sched.md
Name: udma_hyper_ch_sched

Overview:
Per-channel transaction scheduler in front of the multi-ID hyperbus controller. It shares the single hyperbus PHY command path between NB_CH logical channels. Each channel request is split into bursts of at most BURST_BYTES, and the scheduler re-arbitrates round-robin after every burst so that one long transfer cannot starve other channels. It issues one burst at a time to the PHY, tracks completion and raises a per-channel end-of-transfer event.

Parameters:
NB_CH, 8, number of logical channels (at least 2)
TRANS_SIZE, 16, width of byte-length fields
BURST_BYTES, 512, maximum bytes per PHY burst (power of 2, at most 2^(TRANS_SIZE-1))

Ports:
sys_clk_i  in  1  clock; all logic is on its rising edge
rst_i  in  1  synchronous, active-high reset
ch_req_i  in  NB_CH  per-channel transfer request (level)
ch_ack_o  out  NB_CH  1-cycle pulse when the request is captured
ch_addr_i  in  NB_CH x 32  start byte address, sampled on ack
ch_len_i  in  NB_CH x TRANS_SIZE  length in bytes, sampled on ack
ch_rw_i  in  NB_CH  1 = read, 0 = write, sampled on ack
ch_clr_i  in  NB_CH  abort the channel context
trans_valid_o  out  1  burst command valid
trans_ready_i  in  1  PHY accepts the burst command
trans_addr_o  out  32  burst start address
trans_len_o  out  TRANS_SIZE  burst length in bytes
trans_rw_o  out  1  burst direction
trans_id_o  out  $clog2(NB_CH)  channel owning the burst
trans_done_i  in  1  1-cycle pulse when the PHY completes the burst
evt_eot_o  out  NB_CH  1-cycle end-of-transfer pulse
busy_o  out  1  at least one context is active, or the FSM is not IDLE

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - All contexts are cleared, the FSM goes to IDLE and the RR pointer is set to 0.
  - All outputs are 0.
  - Reset during ISSUE or WAIT drops trans_valid_o at that edge. No eot is generated.
- Context capture:
  - Each channel has a context: active, addr[31:0], left[TRANS_SIZE-1:0], rw.
  - If ch_req_i[c] = 1, ctx.active[c] = 0 and ch_clr_i[c] = 0, then ch_ack_o[c] pulses this cycle and the context loads at the edge.
  - Several channels may be acked in the same cycle.
  - len = 0: acked; the context is not activated; evt_eot_o[c] pulses the next cycle; no PHY traffic.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any context is active, select the first active channel at or above the RR pointer, wrapping around.
  - Register the selected id and the chunk, then go to ISSUE.
  - chunk = min(left, BURST_BYTES).
- ISSUE:
  - trans_valid_o = 1. trans_addr, trans_len, trans_rw and trans_id are held stable until trans_ready_i = 1.
  - On handshake go to WAIT; trans_valid_o = 0 from the next cycle.
- WAIT:
  - Wait for trans_done_i.
  - On done: addr += chunk (mod 2^32); left -= chunk; RR pointer = (id + 1) mod NB_CH.
  - If left = 0: clear active and pulse evt_eot_o[id] on the next cycle.
  - Return to IDLE.
- trans_done_i outside WAIT is ignored.
- Latency (PHY ready = 1):
  - Ack at cycle t; IDLE select at t+1; trans_valid_o = 1 at t+2.
  - Minimum gap between bursts is 1 IDLE cycle after done.
- ch_clr_i[c]:
  - If c is not in flight, the context is cleared immediately with no eot.
  - If c is in ISSUE, the command is still presented until accepted (no retraction).
  - If c is in ISSUE or WAIT, the context is marked aborted and cleared on done, with no eot.
  - clr has priority over req in the same cycle; no ack is given.
- Fairness: with N active channels, each gets exactly one burst per N bursts.
- busy_o is registered and reflects (any active) or (state != IDLE).

Test Plan:
1. Single read: ch2, addr 0x1000, len 1200, BURST_BYTES = 512 -> three bursts (0x1000/512, 0x1200/512, 0x1400/176), trans_id = 2 throughout, evt_eot_o[2] pulses 1 cycle after the third done.
2. Round robin: ch0 and ch5 both request len 1024 in the same cycle -> both acked that cycle; burst order ch0, ch5, ch0, ch5; eot on ch0, then eot on ch5.
3. Backpressure: trans_ready_i = 0 for 10 cycles -> trans_valid_o stays 1 with stable fields; handshake on cycle 11; a done asserted before the handshake is ignored.
4. Zero length: ch3 len 0 -> ack, then evt_eot_o[3] on the next cycle; trans_valid_o never asserts.
5. Abort: ch1 len 2048, ch_clr_i[1] asserted in WAIT of the first burst -> no second burst and no eot. A following ch1 request is acked normally.
6. Reset mid-ISSUE: rst_i asserted while trans_valid_o = 1 -> all outputs 0 next cycle, RR pointer 0, contexts inactive.
